// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and encodings for the shift issue unit:
//                sequencer state, shift-box select codes and R-type funct
//                values for the shift instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Sequencer state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shift-box select codes
  localparam logic [2:0] SH_SLL  = 3'b000;
  localparam logic [2:0] SH_SLLV = 3'b001;
  localparam logic [2:0] SH_SRA  = 3'b010;
  localparam logic [2:0] SH_SRAV = 3'b011;
  localparam logic [2:0] SH_SRL  = 3'b100;

  // R-type funct fields for the shift instructions
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

endpackage
`default_nettype wire

// File: rtl/shift_funct_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : shift_funct_decoder
//  Description : Combinational funct decode to shift-box select code, a
//                legality flag and a flag choosing rs[4:0] as shift amount.
//                Optional macro SHIFT_SRLV_EN makes SRLV legal (issued as
//                SRL with the shift amount taken from rs).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_funct_decoder
  import shift_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_code,
  output logic       o_legal,
  output logic       o_use_rs_shamt
);

  // Map funct to select code; anything unrecognised is illegal
  always_comb begin
    o_code         = SH_SLL;
    o_legal        = 1'b1;
    o_use_rs_shamt = 1'b0;
    case (i_funct)
      F_SLL:  o_code = SH_SLL;
      F_SLLV: o_code = SH_SLLV;
      F_SRA:  o_code = SH_SRA;
      F_SRAV: o_code = SH_SRAV;
      F_SRL:  o_code = SH_SRL;
`ifdef SHIFT_SRLV_EN
      // SRLV reuses the immediate SRL path with the amount sourced from rs
      F_SRLV: begin
        o_code         = SH_SRL;
        o_use_rs_shamt = 1'b1;
      end
`endif
      default: o_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_issue_unit
//  Description : Multicycle sequencer around the combinational shift box.
//                Registers a decoded shift instruction, presents operands to
//                the shift box, captures the result and holds it for the
//                register-bank writeback port under a valid/ack handshake.
//                Optional macro SHIFT_SRLV_EN enables the SRLV funct.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_unit
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [5:0]        funct,
  input  logic [SHAMT_W-1:0] shamt_in,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [4:0]        rd_in,
  output logic [DATA_W-1:0] sh_entrada1,
  output logic [DATA_W-1:0] sh_entrada2,
  output logic [SHAMT_W-1:0] sh_shamt,
  output logic [2:0]        sh_code,
  input  logic [DATA_W-1:0] sh_saida,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  input  logic              wb_ack,
  output logic              illegal
);

  logic [2:0]         w_code;
  logic               w_legal;
  logic               w_use_rs_shamt;
  logic               w_unused_rs_hi;

  state_t             r_state;
  logic               r_ready;
  logic               r_illegal;
  logic               r_wb_valid;
  logic [DATA_W-1:0]  r_op1;
  logic [DATA_W-1:0]  r_op2;
  logic [SHAMT_W-1:0] r_shamt;
  logic [2:0]         r_code;
  logic [4:0]         r_rd;
  logic [DATA_W-1:0]  r_wb_data;
  logic [4:0]         r_wb_rd;

  shift_funct_decoder u_decoder (
    .i_funct        (funct),
    .o_code         (w_code),
    .o_legal        (w_legal),
    .o_use_rs_shamt (w_use_rs_shamt)
  );

  // Only rs[4:0] feeds the shift box; upper bits are deliberately dropped
  assign w_unused_rs_hi = ^rs_val[DATA_W-1:SHAMT_W];

  // Sequencer: accept, present operands, capture result, hold for writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_illegal  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_shamt    <= '0;
      r_code     <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_op1   <= rt_val;
              // Zero-extend rs[4:0] so variable shifts never see upper bits
              r_op2   <= {{(DATA_W-SHAMT_W){1'b0}}, rs_val[SHAMT_W-1:0]};
              r_shamt <= w_use_rs_shamt ? rs_val[SHAMT_W-1:0] : shamt_in;
              r_rd    <= rd_in;
              r_code  <= w_code;
              r_ready <= 1'b0;
              r_state <= ST_LOAD;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // Operands are on the shift box inputs this cycle; result settles
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_wb_data <= sh_saida;
          r_wb_rd   <= r_rd;
          if (r_rd == 5'd0) begin
            // Writes to r0 are dropped without a writeback request
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wb_valid <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ack) begin
            r_wb_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign illegal     = r_illegal;
  assign wb_valid    = r_wb_valid;
  assign wb_data     = r_wb_data;
  assign wb_rd       = r_wb_rd;
  assign sh_entrada1 = r_op1;
  assign sh_entrada2 = r_op2;
  assign sh_shamt    = r_shamt;
  assign sh_code     = r_code;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_issue_unit
//  Description : Directed self-checking bench for shift_issue_unit with a
//                behavioural shift box closing the sh_* / sh_saida loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_issue_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic [5:0]  funct;
  logic [4:0]  shamt_in;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  rd_in;
  logic [31:0] sh_entrada1;
  logic [31:0] sh_entrada2;
  logic [4:0]  sh_shamt;
  logic [2:0]  sh_code;
  logic [31:0] sh_saida;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_ack;
  logic        illegal;
  logic        unused_e2_hi;

  int tests_run = 0;
  int tests_failed = 0;

  shift_issue_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .funct       (funct),
    .shamt_in    (shamt_in),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .rd_in       (rd_in),
    .sh_entrada1 (sh_entrada1),
    .sh_entrada2 (sh_entrada2),
    .sh_shamt    (sh_shamt),
    .sh_code     (sh_code),
    .sh_saida    (sh_saida),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_ack      (wb_ack),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign unused_e2_hi = ^sh_entrada2[31:5];

  // Behavioural shift box
  always_comb begin
    sh_saida = 32'h0;
    case (sh_code)
      3'b000: sh_saida = sh_entrada1 << sh_shamt;
      3'b001: sh_saida = sh_entrada1 << sh_entrada2[4:0];
      3'b010: sh_saida = $unsigned($signed(sh_entrada1) >>> sh_shamt);
      3'b011: sh_saida = $unsigned($signed(sh_entrada1) >>> sh_entrada2[4:0]);
      3'b100: sh_saida = sh_entrada1 >> sh_shamt;
      default: sh_saida = 32'h0;
    endcase
  end

  // Present one instruction with start for a single edge; returns 1ns after that edge
  task automatic issue(input logic [5:0] f, input logic [4:0] sa,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    @(negedge clk);
    funct = f; shamt_in = sa; rs_val = rs; rt_val = rt; rd_in = rd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance one clock, landing 1ns after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Acknowledge for exactly one edge
  task automatic do_ack();
    @(negedge clk);
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({ready, wb_valid, illegal} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_flags: got ready/valid/illegal=%b expected 100", {ready, wb_valid, illegal});
    end
    tests_run++;
    if ({sh_code, sh_shamt, sh_entrada1, sh_entrada2, wb_data, wb_rd} !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: code=%h shamt=%h e1=%h e2=%h data=%h rd=%h expected all zero",
               sh_code, sh_shamt, sh_entrada1, sh_entrada2, wb_data, wb_rd);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sll();
    issue(6'b000000, 5'd4, 32'h0, 32'h0000_0001, 5'd8);
    tests_run++;
    if (ready !== 1'b0 || sh_code !== 3'b000 || sh_shamt !== 5'd4 || sh_entrada1 !== 32'h1) begin
      tests_failed++;
      $display("FAIL sll_load: ready=%b code=%b shamt=%0d e1=%h expected 0/000/4/00000001",
               ready, sh_code, sh_shamt, sh_entrada1);
    end
    step();
    tests_run++;
    if (wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sll_early_valid: got %b expected 0", wb_valid);
    end
    step();
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0010 || wb_rd !== 5'd8) begin
      tests_failed++;
      $display("FAIL sll_result: valid=%b data=%h rd=%0d expected 1/00000010/8", wb_valid, wb_data, wb_rd);
    end
    do_ack();
    tests_run++;
    if (wb_valid !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sll_ack: valid=%b ready=%b expected 0/1", wb_valid, ready);
    end
  endtask

  task automatic test_sra();
    issue(6'b000011, 5'd4, 32'h0, 32'h8000_0000, 5'd9);
    tests_run++;
    if (sh_code !== 3'b010) begin
      tests_failed++;
      $display("FAIL sra_code: got %b expected 010", sh_code);
    end
    step(); step();
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hF800_0000 || wb_rd !== 5'd9) begin
      tests_failed++;
      $display("FAIL sra_result: valid=%b data=%h rd=%0d expected 1/f8000000/9", wb_valid, wb_data, wb_rd);
    end
    do_ack();
  endtask

  task automatic test_sllv_mask();
    issue(6'b000100, 5'd0, 32'h0000_0024, 32'h0000_0001, 5'd10);
    tests_run++;
    if (sh_code !== 3'b001 || sh_entrada2 !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL sllv_mask: code=%b e2=%h expected 001/00000004", sh_code, sh_entrada2);
    end
    step(); step();
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0010) begin
      tests_failed++;
      $display("FAIL sllv_result: valid=%b data=%h expected 1/00000010", wb_valid, wb_data);
    end
    do_ack();
  endtask

  task automatic test_backpressure();
    issue(6'b000111, 5'd0, 32'h0000_0008, 32'hF000_0000, 5'd17);
    step(); step();
    // SRAV by 8 of f0000000 -> fff00000
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1; funct = 6'b000000; rd_in = 5'(i + 1); rt_val = 32'h1234_5678;
      @(posedge clk); #1;
      tests_run++;
      if (wb_valid !== 1'b1 || ready !== 1'b0 || wb_data !== 32'hFFF0_0000 || wb_rd !== 5'd17) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b data=%h rd=%0d expected 1/0/fff00000/17",
                 i, wb_valid, ready, wb_data, wb_rd);
      end
    end
    start = 1'b0;
    tests_run++;
    if (sh_code !== 3'b011 || sh_entrada1 !== 32'hF000_0000) begin
      tests_failed++;
      $display("FAIL backpressure_no_accept: code=%b e1=%h expected 011/f0000000", sh_code, sh_entrada1);
    end
    do_ack();
    tests_run++;
    if (ready !== 1'b1 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: ready=%b valid=%b expected 1/0", ready, wb_valid);
    end
  endtask

  task automatic test_rd_zero();
    issue(6'b000010, 5'd4, 32'h0, 32'h0000_00F0, 5'd0);
    step();
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_busy: ready=%b expected 0", ready);
    end
    step();
    tests_run++;
    if (ready !== 1'b1 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_return: ready=%b valid=%b expected 1/0", ready, wb_valid);
    end
    step();
    tests_run++;
    if (wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_no_valid: valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_illegal();
    // ADD funct is never a shift
    issue(6'b100000, 5'd3, 32'h5, 32'h7, 5'd4);
    tests_run++;
    if (illegal !== 1'b1 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_pulse: illegal=%b ready=%b expected 1/1", illegal, ready);
    end
    step();
    tests_run++;
    if (illegal !== 1'b0 || wb_valid !== 1'b0 || sh_code !== 3'b100 || sh_entrada1 !== 32'h0000_00F0) begin
      tests_failed++;
      $display("FAIL illegal_after: illegal=%b valid=%b code=%b e1=%h expected 0/0/100/000000f0",
               illegal, wb_valid, sh_code, sh_entrada1);
    end
`ifndef SHIFT_SRLV_EN
    issue(6'b000110, 5'd0, 32'h4, 32'h8000_0000, 5'd6);
    tests_run++;
    if (illegal !== 1'b1 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL srlv_illegal: illegal=%b ready=%b expected 1/1", illegal, ready);
    end
    step(); step(); step();
    tests_run++;
    if (illegal !== 1'b0 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL srlv_no_wb: illegal=%b valid=%b expected 0/0", illegal, wb_valid);
    end
`endif
  endtask

  task automatic test_srlv();
`ifdef SHIFT_SRLV_EN
    issue(6'b000110, 5'd9, 32'h0000_0004, 32'h8000_0000, 5'd6);
    tests_run++;
    if (illegal !== 1'b0 || sh_code !== 3'b100 || sh_shamt !== 5'd4) begin
      tests_failed++;
      $display("FAIL srlv_load: illegal=%b code=%b shamt=%0d expected 0/100/4", illegal, sh_code, sh_shamt);
    end
    step(); step();
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0800_0000 || wb_rd !== 5'd6) begin
      tests_failed++;
      $display("FAIL srlv_result: valid=%b data=%h rd=%0d expected 1/08000000/6", wb_valid, wb_data, wb_rd);
    end
    do_ack();
`endif
  endtask

  task automatic test_reset_mid();
    issue(6'b000000, 5'd1, 32'h0, 32'h0000_0003, 5'd12);
    step();
    // Now in SHIFT; hit reset between edges
    reset = 1'b1;
    #1;
    tests_run++;
    if (wb_valid !== 1'b0 || ready !== 1'b1 || wb_data !== 32'h0 || sh_code !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b ready=%b data=%h code=%b expected 0/1/00000000/000",
               wb_valid, ready, wb_data, sh_code);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(6'b000010, 5'd4, 32'h0, 32'h0000_00F0, 5'd3);
    step(); step();
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_000F || wb_rd !== 5'd3) begin
      tests_failed++;
      $display("FAIL reset_mid_next: valid=%b data=%h rd=%0d expected 1/0000000f/3", wb_valid, wb_data, wb_rd);
    end
    do_ack();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wb_ack = 1'b0;
    funct = '0; shamt_in = '0; rs_val = '0; rt_val = '0; rd_in = '0;
    test_reset();
    test_sll();
    test_sra();
    test_sllv_mask();
    test_backpressure();
    test_rd_zero();
    test_illegal();
    test_srlv();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
